// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin change payout controller.
//
// Pays out change_in using four coin denominations (DENOM0 is the largest,
// DENOM3 the smallest). It ejects one coin at a time and waits for the
// hopper to acknowledge each coin. Every denomination has its own coin
// count, which load_inventory can refill. If the hopper stops
// acknowledging, the block latches into a sticky FAULT state that only
// reset clears.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   change_in      amount to pay, qualified by change_valid
//   change_valid   one-cycle start strobe (only accepted in IDLE)
//   hopper_ack     hopper confirms one coin ejected (only used in WAIT_ACK)
//   load_inventory refill strobe (only accepted in IDLE)
//   load_denom     refill target index, 0..3
//   load_count     new coin count for load_denom
//   coin_out_pulse one-cycle eject command
//   coin_out_sel   denomination index for the eject command
//   busy           high in every state except IDLE
//   done           one-cycle completion pulse
//   short_pay      valid with done; high if change was not fully paid
//   remaining      amount still owed
//   empty          bit i high when count i is zero
//   fault          hopper timeout, sticky until reset
module change_dispenser #(
  parameter logic [5:0] DENOM0      = 6'd10,
  parameter logic [5:0] DENOM1      = 6'd5,
  parameter logic [5:0] DENOM2      = 6'd2,
  parameter logic [5:0] DENOM3      = 6'd1,
  parameter logic [7:0] INIT_COUNT  = 8'd20,
  parameter logic [3:0] ACK_TIMEOUT = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] change_in,
  input  logic       change_valid,
  input  logic       hopper_ack,
  input  logic       load_inventory,
  input  logic [1:0] load_denom,
  input  logic [7:0] load_count,
  output logic       coin_out_pulse,
  output logic [1:0] coin_out_sel,
  output logic       busy,
  output logic       done,
  output logic       short_pay,
  output logic [5:0] remaining,
  output logic [3:0] empty,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT
  } state_t;

  state_t      state, state_next;
  logic [7:0]  count [4];
  logic [5:0]  denom [4];
  logic [5:0]  rem;
  logic [1:0]  sel;
  logic [3:0]  tcount;
  logic        found;
  logic [1:0]  pick;

  always_comb begin
    denom[0] = DENOM0;
    denom[1] = DENOM1;
    denom[2] = DENOM2;
    denom[3] = DENOM3;
  end

  // Greedy choice: the lowest index that still fits and still has coins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && denom[i] <= rem && count[i] != '0) begin
        found = 1'b1;
        pick  = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (change_valid) state_next = SELECT;
      SELECT:   state_next = (rem != '0 && found) ? EJECT : DONE;
      EJECT:    state_next = WAIT_ACK;
      // An ack that arrives on the final timeout cycle still counts.
      WAIT_ACK: if (hopper_ack)                        state_next = SELECT;
                else if (tcount == ACK_TIMEOUT - 4'd1) state_next = FAULT;
      DONE:     state_next = IDLE;
      FAULT:    state_next = FAULT;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem    <= '0;
      sel    <= '0;
      tcount <= '0;
      for (int unsigned i = 0; i < 4; i++) count[i] <= INIT_COUNT;
    end else begin
      case (state)
        IDLE: begin
          if (change_valid)   rem               <= change_in;
          if (load_inventory) count[load_denom] <= load_count;
        end
        SELECT:   if (rem != '0 && found) sel <= pick;
        EJECT:    tcount <= '0;
        WAIT_ACK: begin
          if (hopper_ack) begin
            rem <= rem - denom[sel];
            if (count[sel] != '0) count[sel] <= count[sel] - 8'd1;
          end else begin
            tcount <= tcount + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    coin_out_pulse = (state == EJECT);
    coin_out_sel   = sel;
    busy           = (state != IDLE);
    done           = (state == DONE);
    short_pay      = (state == DONE) && (rem != '0);
    fault          = (state == FAULT);
    remaining      = rem;
    for (int unsigned i = 0; i < 4; i++) empty[i] = (count[i] == '0);
  end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] change_in = '0;
  logic       change_valid = 1'b0;
  logic       hopper_ack = 1'b0;
  logic       load_inventory = 1'b0;
  logic [1:0] load_denom = '0;
  logic [7:0] load_count = '0;
  logic       coin_out_pulse;
  logic [1:0] coin_out_sel;
  logic       busy, done, short_pay, fault;
  logic [5:0] remaining;
  logic [3:0] empty;

  int n_cmp = 0;
  int n_bad = 0;

  int         pulses;
  int         dones;
  logic [1:0] sels [$];

  change_dispenser #(
    .DENOM0(6'd10), .DENOM1(6'd5), .DENOM2(6'd2), .DENOM3(6'd1),
    .INIT_COUNT(8'd20), .ACK_TIMEOUT(4'd15)
  ) dut (
    .clk(clk), .reset(reset), .change_in(change_in), .change_valid(change_valid),
    .hopper_ack(hopper_ack), .load_inventory(load_inventory), .load_denom(load_denom),
    .load_count(load_count), .coin_out_pulse(coin_out_pulse), .coin_out_sel(coin_out_sel),
    .busy(busy), .done(done), .short_pay(short_pay), .remaining(remaining),
    .empty(empty), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      pulses = 0;
      dones  = 0;
      sels.delete();
    end else begin
      if (coin_out_pulse) begin
        pulses = pulses + 1;
        sels.push_back(coin_out_sel);
      end
      if (done) dones = dones + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    change_valid = 1'b0; hopper_ack = 1'b0; load_inventory = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start_change(input logic [5:0] v);
    change_in = v;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
  endtask

  // Acks each coin two cycles after its eject pulse; stops at done.
  task automatic run_payout(output logic seen, output logic sp, output logic [5:0] rem_v);
    int ack_due = 0;
    seen = 1'b0; sp = 1'b0; rem_v = '0;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (k != 0) @(negedge clk);
      hopper_ack = 1'b0;
      if (done) begin
        seen = 1'b1; sp = short_pay; rem_v = remaining;
      end else if (coin_out_pulse) begin
        ack_due = 2;
      end else if (ack_due > 0) begin
        ack_due--;
        if (ack_due == 0) hopper_ack = 1'b1;
      end
    end
    hopper_ack = 1'b0;
  endtask

  task automatic wait_pulse(input string name);
    int k = 0;
    while (!coin_out_pulse && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!coin_out_pulse) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no coin_out_pulse within 50 cycles", name);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({busy, done, short_pay, fault, coin_out_pulse} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00000", {busy, done, short_pay, fault, coin_out_pulse});
    end
    n_cmp++; if (remaining !== 6'd0) begin
      n_bad++; $display("FAIL reset_remaining: got %0d want 0", remaining);
    end
    n_cmp++; if (coin_out_sel !== 2'd0) begin
      n_bad++; $display("FAIL reset_sel: got %0d want 0", coin_out_sel);
    end
    n_cmp++; if (empty !== 4'b0000) begin
      n_bad++; $display("FAIL reset_empty: got %b want 0000", empty);
    end
  endtask

  task automatic test_full_change();
    logic seen, sp; logic [5:0] r;
    logic [7:0] got_sels;
    do_reset();
    start_change(6'd23);
    run_payout(seen, sp, r);
    got_sels = (sels.size() == 4) ? {sels[0], sels[1], sels[2], sels[3]} : 8'hxx;
    n_cmp++; if ({seen, sp, r} !== {1'b1, 1'b0, 6'd0}) begin
      n_bad++; $display("FAIL c23_done: got seen=%b sp=%b rem=%0d want 1 0 0", seen, sp, r);
    end
    n_cmp++; if (pulses !== 4) begin
      n_bad++; $display("FAIL c23_pulses: got %0d want 4", pulses);
    end
    n_cmp++; if (got_sels !== 8'b00_00_10_11) begin
      n_bad++; $display("FAIL c23_sels: got %b want 00001011", got_sels);
    end
    @(negedge clk);
    n_cmp++; if ({done, busy} !== 2'b00) begin
      n_bad++; $display("FAIL c23_done_width: got done,busy=%b want 00", {done, busy});
    end
    hopper_ack = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if ({remaining, busy} !== {6'd0, 1'b0}) begin
      n_bad++; $display("FAIL idle_ack_ignored: got rem=%0d busy=%b want 0 0", remaining, busy);
    end
  endtask

  task automatic test_short_pay();
    logic seen, sp; logic [5:0] r;
    do_reset();
    load_inventory = 1'b1; load_denom = 2'd3; load_count = 8'd0;
    @(negedge clk);
    load_inventory = 1'b0;
    n_cmp++; if (empty !== 4'b1000) begin
      n_bad++; $display("FAIL load_empty: got %b want 1000", empty);
    end
    start_change(6'd3);
    run_payout(seen, sp, r);
    n_cmp++; if ({seen, sp, r} !== {1'b1, 1'b1, 6'd1}) begin
      n_bad++; $display("FAIL short_done: got seen=%b sp=%b rem=%0d want 1 1 1", seen, sp, r);
    end
    n_cmp++; if (pulses !== 1 || sels.size() != 1 || sels[0] !== 2'd2) begin
      n_bad++; $display("FAIL short_eject: got pulses=%0d want 1 of sel 2", pulses);
    end
    @(negedge clk);
    n_cmp++; if ({remaining, empty} !== {6'd1, 4'b1000}) begin
      n_bad++; $display("FAIL short_hold: got rem=%0d empty=%b want 1 1000", remaining, empty);
    end
  endtask

  task automatic test_zero_change();
    do_reset();
    start_change(6'd0);
    n_cmp++; if ({done, busy} !== 2'b01) begin
      n_bad++; $display("FAIL zero_cycle1: got done,busy=%b want 01", {done, busy});
    end
    @(negedge clk);
    n_cmp++; if ({done, short_pay} !== 2'b10) begin
      n_bad++; $display("FAIL zero_done: got done,short_pay=%b want 10", {done, short_pay});
    end
    n_cmp++; if (pulses !== 0) begin
      n_bad++; $display("FAIL zero_pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_load_with_change();
    logic seen, sp; logic [5:0] r;
    do_reset();
    load_inventory = 1'b1; load_denom = 2'd0; load_count = 8'd0;
    start_change(6'd10);
    load_inventory = 1'b0;
    run_payout(seen, sp, r);
    n_cmp++; if ({seen, sp, r} !== {1'b1, 1'b0, 6'd0}) begin
      n_bad++; $display("FAIL loadchg_done: got seen=%b sp=%b rem=%0d want 1 0 0", seen, sp, r);
    end
    n_cmp++; if (pulses !== 2 || sels.size() != 2 || sels[0] !== 2'd1 || sels[1] !== 2'd1) begin
      n_bad++; $display("FAIL loadchg_ejects: got pulses=%0d want 2 of sel 1", pulses);
    end
    n_cmp++; if (empty !== 4'b0001) begin
      n_bad++; $display("FAIL loadchg_empty: got %b want 0001", empty);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    start_change(6'd5);
    wait_pulse("timeout_pulse");
    n_cmp++; if (coin_out_sel !== 2'd1) begin
      n_bad++; $display("FAIL timeout_sel: got %0d want 1", coin_out_sel);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (fault) break;
      n++;
    end
    n_cmp++; if (n !== 15 || fault !== 1'b1) begin
      n_bad++; $display("FAIL timeout_cycles: got %0d cycles fault=%b want 15 1", n, fault);
    end
    start_change(6'd3);
    repeat (5) @(negedge clk);
    n_cmp++; if ({fault, busy, done} !== 3'b110 || pulses !== 1 || remaining !== 6'd5 || dones !== 0) begin
      n_bad++; $display("FAIL fault_sticky: got f,b,d=%b pulses=%0d rem=%0d dones=%0d want 110 1 5 0",
                        {fault, busy, done}, pulses, remaining, dones);
    end
  endtask

  task automatic test_ack_at_timeout();
    logic seen, sp; logic [5:0] r;
    do_reset();
    start_change(6'd5);
    wait_pulse("late_ack_pulse");
    repeat (15) @(negedge clk);
    hopper_ack = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
    n_cmp++; if (fault !== 1'b0) begin
      n_bad++; $display("FAIL late_ack_fault: got %b want 0", fault);
    end
    run_payout(seen, sp, r);
    n_cmp++; if ({seen, sp, r, fault} !== {1'b1, 1'b0, 6'd0, 1'b0}) begin
      n_bad++; $display("FAIL late_ack_done: got seen=%b sp=%b rem=%0d fault=%b want 1 0 0 0", seen, sp, r, fault);
    end
  endtask

  task automatic test_back_to_back();
    logic seen, sp; logic [5:0] r;
    do_reset();
    start_change(6'd10);
    wait_pulse("b2b_pulse");
    @(negedge clk);
    change_in = 6'd7; change_valid = 1'b1;
    load_inventory = 1'b1; load_denom = 2'd2; load_count = 8'd0;
    @(negedge clk);
    change_valid = 1'b0; load_inventory = 1'b0;
    hopper_ack = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
    run_payout(seen, sp, r);
    n_cmp++; if ({seen, sp, r} !== {1'b1, 1'b0, 6'd0} || pulses !== 1) begin
      n_bad++; $display("FAIL b2b_done: got seen=%b sp=%b rem=%0d pulses=%0d want 1 0 0 1", seen, sp, r, pulses);
    end
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, remaining, empty} !== {1'b0, 6'd0, 4'b0000} || dones !== 1) begin
      n_bad++; $display("FAIL b2b_ignored: got busy=%b rem=%0d empty=%b dones=%0d want 0 0 0000 1",
                        busy, remaining, empty, dones);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_inventory = 1'b1; load_denom = 2'd2; load_count = 8'd0;
    @(negedge clk);
    load_inventory = 1'b0;
    start_change(6'd20);
    wait_pulse("rst_mid_pulse");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, done, remaining, empty} !== {1'b0, 1'b0, 6'd0, 4'b0000}) begin
      n_bad++; $display("FAIL rst_mid_state: got busy=%b done=%b rem=%0d empty=%b want 0 0 0 0000",
                        busy, done, remaining, empty);
    end
    reset = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (dones !== 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_nodone: got dones=%0d busy=%b want 0 0", dones, busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_change();
    test_short_pay();
    test_zero_change();
    test_load_with_change();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL provide parameter DENOM0, default 6'd10, largest coin value.
REQ-002 SHALL provide parameter DENOM1, default 6'd5.
REQ-003 SHALL provide parameter DENOM2, default 6'd2.
REQ-004 SHALL provide parameter DENOM3, default 6'd1, smallest coin value.
REQ-005 SHALL provide parameter INIT_COUNT, default 8'd20, per-denomination coin count at reset.
REQ-006 SHALL provide parameter ACK_TIMEOUT, default 4'd15, maximum cycles to wait for hopper_ack.
REQ-007 SHALL use one clock; reset is synchronous and active-low.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 reset  input  1  synchronous, active-low reset.
REQ-010 change_in  input  6  change amount from the vend controller.
REQ-011 change_valid  input  1  one-cycle strobe qualifying change_in.
REQ-012 hopper_ack  input  1  hopper confirms one coin ejected.
REQ-013 load_inventory  input  1  refill strobe.
REQ-014 load_denom  input  2  refill target, 0..3 = DENOM0..DENOM3.
REQ-015 load_count  input  8  new coin count for load_denom.
REQ-016 coin_out_pulse  output  1  one-cycle eject command to hopper.
REQ-017 coin_out_sel  output  2  denomination index for the eject command.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle completion pulse.
REQ-020 short_pay  output  1  valid with done; high if change could not be fully paid.
REQ-021 remaining  output  6  amount still owed.
REQ-022 empty  output  4  bit i high when count i == 0.
REQ-023 fault  output  1  hopper timeout, sticky.

Function
REQ-024 SHALL implement the states IDLE, SELECT, EJECT, WAIT_ACK, DONE and FAULT.
REQ-025 IDLE + change_valid: latch change_in into remaining and go to SELECT next cycle; change_valid outside IDLE SHALL be ignored.
REQ-026 SELECT (1 cycle): pick the lowest index i with DENOMi <= remaining and count i > 0; if found, go to EJECT; otherwise go to DONE; remaining == 0 goes to DONE.
REQ-027 EJECT (1 cycle): coin_out_pulse = 1 and coin_out_sel = i, then go to WAIT_ACK with the timeout counter cleared.
REQ-028 WAIT_ACK + hopper_ack: subtract DENOMi from remaining, decrement count i, return to SELECT.
REQ-029 WAIT_ACK without hopper_ack: increment the timeout counter; reaching ACK_TIMEOUT goes to FAULT.
REQ-030 If hopper_ack arrives in the same cycle the timeout expires, hopper_ack SHALL win.
REQ-031 hopper_ack outside WAIT_ACK SHALL be ignored.
REQ-032 DONE (1 cycle): done = 1, short_pay = (remaining != 0), then go to IDLE; remaining holds until the next change_valid.
REQ-033 FAULT: fault = 1 and busy = 1; change_valid SHALL be ignored; only reset exits FAULT.
REQ-034 load_inventory in IDLE SHALL write load_count to count[load_denom] and SHALL be ignored in all other states.
REQ-035 If load_inventory and change_valid arrive in the same IDLE cycle, both SHALL take effect, and SELECT uses the loaded count.
REQ-036 Counts SHALL saturate at 0 and never wrap; remaining SHALL never underflow, because selection guarantees DENOMi <= remaining.
REQ-037 Latency for change 0 SHALL be change_valid -> done after 2 cycles, with no ejects.

Reset
REQ-038 On reset low at a clock edge, SHALL enter IDLE and clear coin_out_pulse, coin_out_sel, busy, done, short_pay, remaining, fault and the timeout counter.
REQ-039 On reset, all counts SHALL be set to INIT_COUNT, so empty = 4'b0000.
REQ-040 Reset mid-operation SHALL abandon the payout with no done pulse.

Verification
REQ-041 change 23, full inventory -> eject sequence 0,0,2,3 (10,10,2,1), each acked 2 cycles after coin_out_pulse; done with short_pay = 0, remaining = 0; counts 18,20,19,19.
REQ-042 count3 loaded to 0, change 3 -> one DENOM2 eject; done with short_pay = 1, remaining = 1; empty = 4'b1000.
REQ-043 change 0 -> done 2 cycles after change_valid; no coin_out_pulse; short_pay = 0.
REQ-044 change 5, hopper_ack withheld -> fault = 1 after 15 WAIT_ACK cycles, busy stays 1, and a subsequent change_valid is ignored.
REQ-045 change 10 with a second change_valid of 7 during WAIT_ACK -> the second strobe is ignored, exactly one eject occurs, and remaining ends at 0.
REQ-046 reset low during WAIT_ACK of change 20 -> next cycle IDLE, remaining = 0, counts = INIT_COUNT, no done pulse.
